// File: rtl/snake_key_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module   : snake_key_cmd_encoder
// Purpose  : Front end for the snake game's keys. It synchronises and
//            debounces four active-low pushbuttons and turns press events
//            into 2-bit direction commands. The commands go into a small
//            FIFO that the HPS reads over Avalon-MM. The last accepted
//            command is shown on an active-low 7-segment digit.
// Ports    : clk, reset        - clock, asynchronous active-high reset
//            key_n[3:0]        - raw active-low buttons (async to clk)
//            avs_address[1:0]  - 0 DATA(R) 1 STATUS(R) 2 CONTROL(W) 3 none
//            avs_read/write    - Avalon-MM strobes
//            avs_writedata     - write data
//            avs_readdata      - registered read data (1-cycle latency)
//            irq               - irq_en AND FIFO non-empty
//            cmd_hex[6:0]      - {g,f,e,d,c,b,a}, active low
// Options  : `define SNAKE_CMD_REVERSE_FILTER_EN drops a press whose command
//            is the 180-degree reversal of the last accepted command.
// Revision : 1.0 - initial release
// ============================================================================
module snake_key_cmd_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq,
    output logic [6:0]  cmd_hex
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_LVL_W-1:0] c_FULL    = c_LVL_W'(FIFO_DEPTH);
    localparam logic [1:0] c_ADDR_DATA   = 2'd0;
    localparam logic [1:0] c_ADDR_STATUS = 2'd1;
    localparam logic [1:0] c_ADDR_CTRL   = 2'd2;

    function automatic logic [6:0] cmd_to_hex(input logic [1:0] cmd);
        logic [6:0] seg;
        case (cmd)
            2'd0:    seg = 7'b1000001; // UP
            2'd1:    seg = 7'b0101111; // RIGHT
            2'd2:    seg = 7'b0100001; // DOWN
            default: seg = 7'b1000111; // LEFT
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Two-flop synchroniser. It resets to '1' so that the keys start out
    // released.
    // ------------------------------------------------------------------
    logic [3:0] key_meta_q;
    logic [3:0] key_sync_q;
    logic [3:0] key_stable_q;
    logic [3:0] press_evt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_meta_q <= 4'hF;
            key_sync_q <= 4'hF;
        end else begin
            key_meta_q <= key_n;
            key_sync_q <= key_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Per-key debounce. The counter runs only while the synced value
    // differs from the stable value. A press event is the cycle in which a
    // pressed (0) level gets committed.
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < 4; k++) begin : g_key
            logic [c_CNT_W-1:0] cnt_q;
            logic               differs;
            logic               commit;

            assign differs      = key_sync_q[k] != key_stable_q[k];
            assign commit       = differs && (cnt_q == c_CNT_MAX);
            assign press_evt[k] = commit && !key_sync_q[k];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q           <= '0;
                    key_stable_q[k] <= 1'b1;
                end else if (!differs || commit) begin
                    cnt_q <= '0;
                    if (commit) begin
                        key_stable_q[k] <= key_sync_q[k];
                    end
                end else begin
                    cnt_q <= cnt_q + c_CNT_W'(1);
                end
            end
        end
    endgenerate

    // The highest key index wins. Lower simultaneous presses are dropped.
    logic       evt_valid;
    logic [1:0] evt_cmd;

    always_comb begin
        evt_valid = |press_evt;
        evt_cmd   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (press_evt[k]) begin
                evt_cmd = 2'(k);
            end
        end
    end

    // ------------------------------------------------------------------
    // Register-interface decode and FIFO control
    // ------------------------------------------------------------------
    logic [1:0]         mem_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q;
    logic [c_PTR_W-1:0] rd_ptr_q;
    logic [c_LVL_W-1:0] level_q;
    logic               overflow_q;
    logic               irq_en_q;
    logic [6:0]         cmd_hex_q;
    logic [31:0]        readdata_q;

    logic fifo_empty, fifo_full, ctrl_wr, flush, pop, push, push_req, ovf_evt;
    logic evt_blocked;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == c_FULL);
    assign ctrl_wr    = avs_write && (avs_address == c_ADDR_CTRL);
    assign flush      = ctrl_wr && avs_writedata[1];
    assign pop        = avs_read && (avs_address == c_ADDR_DATA) && !fifo_empty;

`ifdef SNAKE_CMD_REVERSE_FILTER_EN
    logic [1:0] last_cmd_q;
    logic       last_cmd_valid_q;

    assign evt_blocked = last_cmd_valid_q && (evt_cmd == (last_cmd_q ^ 2'b10));

    // Flush re-arms the filter, so any direction is accepted next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_cmd_q       <= 2'd0;
            last_cmd_valid_q <= 1'b0;
        end else if (flush) begin
            last_cmd_valid_q <= 1'b0;
        end else if (push) begin
            last_cmd_q       <= evt_cmd;
            last_cmd_valid_q <= 1'b1;
        end
    end
`else
    assign evt_blocked = 1'b0;
`endif

    assign push_req = evt_valid && !evt_blocked;
    // A full FIFO refuses a push even when a pop happens in the same cycle.
    // Flush also discards a push in the same cycle.
    assign push     = push_req && !fifo_full && !flush;
    assign ovf_evt  = push_req && fifo_full;

    // STATUS has a 5-bit level field.
    logic [31:0] level_ext;
    logic [31:0] status_word;
    logic        w_unused;

    assign level_ext   = 32'(level_q);
    assign status_word = {22'd0, irq_en_q, overflow_q, 3'd0, level_ext[4:0]};
    assign w_unused    = ^{avs_writedata[31:3], level_ext[31:5]};

    // The storage array is not reset. Its contents are only meaningful
    // through level_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= evt_cmd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            irq_en_q   <= 1'b0;
            cmd_hex_q  <= 7'b1111111;
            readdata_q <= 32'd0;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   level_q <= level_q + c_LVL_W'(1);
                    2'b01:   level_q <= level_q - c_LVL_W'(1);
                    default: level_q <= level_q;
                endcase
            end

            // If a new overflow and a clear arrive in the same cycle, the
            // bit stays set.
            if (ovf_evt) begin
                overflow_q <= 1'b1;
            end else if (ctrl_wr && avs_writedata[2]) begin
                overflow_q <= 1'b0;
            end

            if (ctrl_wr) begin
                irq_en_q <= avs_writedata[0];
            end

            if (push) begin
                cmd_hex_q <= cmd_to_hex(evt_cmd);
            end

            if (avs_read) begin
                case (avs_address)
                    c_ADDR_DATA:   readdata_q <= fifo_empty ? 32'd0
                                               : {1'b1, 29'd0, mem_q[rd_ptr_q]};
                    c_ADDR_STATUS: readdata_q <= status_word;
                    default:       readdata_q <= 32'd0;
                endcase
            end
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = irq_en_q && !fifo_empty;
    assign cmd_hex      = cmd_hex_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_key_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_key_cmd_encoder
// Purpose  : Self-checking bench for snake_key_cmd_encoder. A queue-based
//            behavioural model predicts irq, cmd_hex and read data on every
//            cycle. Directed scenarios also pin literal expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_key_cmd_encoder;

    localparam int DEB   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  key_n = 4'hF;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [6:0]  cmd_hex;

    always #5 clk = ~clk;

    snake_key_cmd_encoder #(
        .DEBOUNCE_CYCLES (DEB),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_n         (key_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .cmd_hex       (cmd_hex)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [6:0]  hex_tbl [4] = '{7'b1000001, 7'b0101111, 7'b0100001, 7'b1000111};
    logic [3:0]  m_s1, m_s2, m_stable, m_press;
    int          m_run [4];
    int          m_q [$];
    bit          m_ovf, m_irq_en, m_last_valid, m_rd_chk;
    int          m_last;
    logic [6:0]  m_hex;
    logic [31:0] m_rd_exp;
    int          m_pre, m_cmd;
    bit          m_ev, m_ctrl, m_flush, m_ovf_set;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_s1 = 4'hF; m_s2 = 4'hF; m_stable = 4'hF;
                for (int k = 0; k < 4; k++) m_run[k] = 0;
                m_q.delete();
                m_ovf = 0; m_irq_en = 0; m_last_valid = 0; m_last = 0;
                m_hex = 7'b1111111; m_rd_exp = 32'd0; m_rd_chk = 1;
            end else begin
                // A key level counts once it has been seen, different from
                // the stable value, on DEB consecutive edges.
                m_press = 4'h0;
                for (int k = 0; k < 4; k++) begin
                    if (m_s2[k] != m_stable[k]) begin
                        m_run[k]++;
                        if (m_run[k] == DEB) begin
                            m_stable[k] = m_s2[k];
                            m_run[k] = 0;
                            if (!m_s2[k]) m_press[k] = 1'b1;
                        end
                    end else begin
                        m_run[k] = 0;
                    end
                end
                m_s2 = m_s1;
                m_s1 = key_n;

                m_ev = 0; m_cmd = 0;
                for (int k = 0; k < 4; k++) if (m_press[k]) begin m_ev = 1; m_cmd = k; end
`ifdef SNAKE_CMD_REVERSE_FILTER_EN
                if (m_ev && m_last_valid && m_cmd == (m_last ^ 2)) m_ev = 0;
`endif
                m_pre    = m_q.size();
                m_rd_chk = avs_read;
                if (avs_read) begin
                    case (avs_address)
                        2'd0: begin
                            if (m_pre > 0) m_rd_exp = 32'h8000_0000 | 32'(m_q.pop_front());
                            else           m_rd_exp = 32'd0;
                        end
                        2'd1: m_rd_exp = 32'(m_pre & 31) | (32'(m_ovf) << 8) | (32'(m_irq_en) << 9);
                        default: m_rd_exp = 32'd0;
                    endcase
                end
                m_ctrl    = avs_write && (avs_address == 2'd2);
                m_flush   = m_ctrl && avs_writedata[1];
                m_ovf_set = m_ev && (m_pre == DEPTH);
                if (m_ev && m_pre < DEPTH && !m_flush) begin
                    m_q.push_back(m_cmd);
                    m_last = m_cmd; m_last_valid = 1;
                    m_hex = hex_tbl[m_cmd];
                end
                if (m_flush) begin
                    m_q.delete();
                    m_last_valid = 0;
                end
                if (m_ctrl) begin
                    m_irq_en = avs_writedata[0];
                    if (avs_writedata[2]) m_ovf = 0;
                end
                if (m_ovf_set) m_ovf = 1;
            end
        end
    end

    // Compare process, which runs on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("irq", 32'(irq), 32'(m_irq_en && (m_q.size() > 0)));
            check("cmd_hex", 32'(cmd_hex), 32'(m_hex));
            if (m_rd_chk) check("readdata", avs_readdata, m_rd_exp);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        tick(1);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        avs_address = a; avs_write = 1'b1; avs_writedata = v;
        tick(1);
        avs_write = 1'b0; avs_writedata = 32'd0;
    endtask

    task automatic press(input int k, input int hold);
        key_n[k] = 1'b0;
        tick(hold);
        key_n[k] = 1'b1;
        tick(hold);
    endtask

    logic [31:0] d;

    initial begin
        // Reset state and idle keys.
        tick(3);
        reset = 1'b0;
        tick(20);
        check("idle_irq", 32'(irq), 32'd0);
        check("idle_hex", 32'(cmd_hex), 32'h7F);
        rd(2'd1, d); check("idle_status", d, 32'd0);

        // Glitches on key2, then a real press.
        repeat (2) begin
            key_n[2] = 1'b0; tick(3);
            key_n[2] = 1'b1; tick(3);
        end
        key_n[2] = 1'b0; tick(10);
        key_n[2] = 1'b1; tick(10);
        rd(2'd1, d); check("glitch_level", d, 32'h1);
        check("down_hex", 32'(cmd_hex), 32'b0100001);
        rd(2'd0, d); check("down_data", d, 32'h8000_0002);
        rd(2'd1, d); check("after_pop_status", d, 32'd0);

        // Interrupt behaviour.
        wr(2'd2, 32'h1);
        press(0, 8);
        check("irq_set", 32'(irq), 32'd1);
        rd(2'd0, d); check("up_data", d, 32'h8000_0000);
        check("irq_clr", 32'(irq), 32'd0);
        rd(2'd0, d); check("empty_data", d, 32'd0);

        // Simultaneous keys 1 and 3.
        key_n = 4'b0101; tick(8);
        key_n = 4'hF;    tick(8);
        rd(2'd1, d); check("simul_status", d, 32'h201);
        rd(2'd0, d); check("simul_data", d, 32'h8000_0003);

        // Overflow with 9 events.
        wr(2'd2, 32'h0);
        for (int i = 0; i < 9; i++) press(i % 4, 8);
        rd(2'd1, d); check("ovf_status", d, 32'h108);
        for (int i = 0; i < 8; i++) begin
            rd(2'd0, d); check("ovf_order", d, 32'h8000_0000 | 32'(i % 4));
        end
        wr(2'd2, 32'h4);
        rd(2'd1, d); check("ovf_cleared", d, 32'h0);

        // Reversal filter; without it both commands are queued.
        press(0, 8);
        press(2, 8);
        rd(2'd1, d);
`ifdef SNAKE_CMD_REVERSE_FILTER_EN
        check("rev_level", d, 32'h1);
`else
        check("rev_level", d, 32'h2);
`endif
        wr(2'd2, 32'h2);
        rd(2'd1, d); check("flush_status", d, 32'h0);
        press(2, 8);
        rd(2'd1, d); check("post_flush_level", d, 32'h1);
        check("post_flush_hex", 32'(cmd_hex), 32'b0100001);
        rd(2'd0, d); check("post_flush_data", d, 32'h8000_0002);

        // Reset in the middle of operation.
        wr(2'd2, 32'h1);
        press(1, 8);
        check("pre_reset_irq", 32'(irq), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_hex", 32'(cmd_hex), 32'h7F);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_rdata", avs_readdata, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(2);
        rd(2'd1, d); check("reset_status", d, 32'h0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
